// File: rtl/audio_sfm_reader.sv
// SPI NOR (mode 0) page-read engine for one audio Sfm channel.
// It streams whole 256-byte pages to the sample FIFO and also provides a manual CPU byte path.
module audio_sfm_reader #(
  parameter int unsigned pSfmPageWidth = 16,
  parameter logic [7:0]  pCmdRead      = 8'h03
) (
  input  logic                     iSCLK,
  input  logic                     iSRST,
  input  logic                     iSfmEn,
  input  logic [7:0]               iSfmDiv,
  input  logic [7:0]               iSfmCsHoldTime,
  input  logic [pSfmPageWidth-1:0] iSfmStartAdrs,
  input  logic [pSfmPageWidth-1:0] iSfmEndAdrs,
  output logic                     oSfmDone,
  output logic [pSfmPageWidth-1:0] oSfmAdrsAdd,
  input  logic                     iSfmCpuValid,
  input  logic                     iSfmCpuEn,
  input  logic                     iSfmCpuCsCtrl,
  input  logic [7:0]               iSfmCpuWd,
  output logic [7:0]               oSfmCpuRd,
  output logic                     oSfmCpuDone,
  output logic [7:0]               oSfmRd,
  output logic                     oSfmVd,
  input  logic                     iSfmFull,
  output logic                     oSpiSck,
  output logic                     oSpiCs,
  output logic                     oSpiMosi,
  input  logic                     iSpiMiso
);

  localparam int unsigned CmdW = 32;

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, CMD, DATA, CS_END, CPU_SHIFT, CPU_WAIT
  } state_t;

  state_t          state;
  logic [7:0]      hold_cnt;
  logic [7:0]      div_cnt;
  logic [7:0]      byte_cnt;
  logic [7:0]      rx;
  logic [4:0]      bit_cnt;
  logic [CmdW-1:0] tx;
  logic            gap;

  logic            shifting;
  logic            tick;
  logic            unit_end;
  logic            hold_done;
  logic [4:0]      last_bit;
  logic [CmdW-1:0] cmd_word;

  // A shift unit is the 32-bit command, one data byte, or one CPU byte.
  always_comb begin
    shifting  = (state == CMD) || (state == CPU_SHIFT) || ((state == DATA) && !gap);
    tick      = (div_cnt == iSfmDiv);
    last_bit  = (state == CMD) ? 5'd31 : 5'd7;
    unit_end  = shifting && tick && oSpiSck && (bit_cnt == last_bit);
    hold_done = (9'(hold_cnt) + 9'd1) >= 9'(iSfmCsHoldTime);
    cmd_word  = {pCmdRead, 24'({oSfmAdrsAdd, 8'h00})};
  end

  always_ff @(posedge iSCLK) begin
    if (iSRST) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      div_cnt     <= '0;
      byte_cnt    <= '0;
      rx          <= '0;
      bit_cnt     <= '0;
      tx          <= '0;
      gap         <= 1'b0;
      oSfmDone    <= 1'b0;
      oSfmAdrsAdd <= '0;
      oSfmCpuRd   <= '0;
      oSfmCpuDone <= 1'b0;
      oSfmRd      <= '0;
      oSfmVd      <= 1'b0;
      oSpiSck     <= 1'b0;
      oSpiCs      <= 1'b1;
      oSpiMosi    <= 1'b0;
    end else begin
      oSfmDone    <= 1'b0;
      oSfmCpuDone <= 1'b0;
      oSfmVd      <= 1'b0;

      // Bit engine: SCK toggles every iSfmDiv+1 clocks; MISO in on rise, MOSI out on fall.
      if (shifting) begin
        if (tick) begin
          div_cnt <= '0;
          if (!oSpiSck) begin
            oSpiSck <= 1'b1;
            rx      <= {rx[6:0], iSpiMiso};
          end else begin
            oSpiSck <= 1'b0;
            if (bit_cnt != last_bit) begin
              bit_cnt  <= bit_cnt + 5'd1;
              oSpiMosi <= tx[CmdW-1];
              tx       <= {tx[CmdW-2:0], 1'b0};
            end
          end
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end

      case (state)
        IDLE: begin
          oSpiSck  <= 1'b0;
          oSpiCs   <= iSfmCpuValid ? iSfmCpuCsCtrl : 1'b1;
          hold_cnt <= '0;
          div_cnt  <= '0;
          gap      <= 1'b0;
          if (iSfmCpuValid && iSfmCpuEn) begin
            oSpiMosi <= iSfmCpuWd[7];
            tx       <= {iSfmCpuWd[6:0], 25'd0};
            bit_cnt  <= '0;
            state    <= CPU_SHIFT;
          end else if (!iSfmCpuValid && iSfmEn) begin
            oSfmAdrsAdd <= iSfmStartAdrs;
            oSpiCs      <= 1'b0;
            state       <= CS_SETUP;
          end
        end

        CS_SETUP: begin
          oSpiCs <= 1'b0;
          if (!iSfmEn) begin
            oSpiCs   <= 1'b1;
            hold_cnt <= '0;
            state    <= CS_END;
          end else if (hold_done) begin
            oSpiMosi <= cmd_word[CmdW-1];
            tx       <= {cmd_word[CmdW-2:0], 1'b0};
            bit_cnt  <= '0;
            div_cnt  <= '0;
            state    <= CMD;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        CMD: begin
          if (unit_end) begin
            if (!iSfmEn) begin
              oSpiCs   <= 1'b1;
              hold_cnt <= '0;
              state    <= CS_END;
            end else begin
              gap      <= 1'b1;
              byte_cnt <= '0;
              state    <= DATA;
            end
          end
        end

        // gap marks a byte boundary; a new byte only starts once the FIFO has room.
        DATA: begin
          if (gap) begin
            if (!iSfmEn) begin
              oSpiCs   <= 1'b1;
              hold_cnt <= '0;
              state    <= CS_END;
            end else if (!iSfmFull) begin
              gap      <= 1'b0;
              bit_cnt  <= '0;
              div_cnt  <= '0;
              oSpiMosi <= 1'b0;
              tx       <= '0;
            end
          end else if (unit_end) begin
            oSfmRd <= rx;
            oSfmVd <= 1'b1;
            if ((byte_cnt == 8'hFF) || !iSfmEn) begin
              oSpiCs   <= 1'b1;
              hold_cnt <= '0;
              state    <= CS_END;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
              gap      <= 1'b1;
            end
          end
        end

        CS_END: begin
          oSpiCs <= 1'b1;
          if (hold_done) begin
            hold_cnt <= '0;
            if (!iSfmEn) begin
              state <= IDLE;
            end else if (oSfmAdrsAdd == iSfmEndAdrs) begin
              oSfmDone <= 1'b1;
              state    <= IDLE;
            end else begin
              oSfmAdrsAdd <= oSfmAdrsAdd + pSfmPageWidth'(1);
              oSpiCs      <= 1'b0;
              state       <= CS_SETUP;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        CPU_SHIFT: begin
          oSpiCs <= iSfmCpuCsCtrl;
          if (unit_end) begin
            oSfmCpuRd   <= rx;
            oSfmCpuDone <= 1'b1;
            state       <= CPU_WAIT;
          end
        end

        CPU_WAIT: begin
          oSpiCs <= iSfmCpuCsCtrl;
          if (!iSfmCpuEn) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_sfm_reader.sv
// Bench for audio_sfm_reader: behavioural SPI flash model plus byte/command scoreboards.
module tb_audio_sfm_reader;
  localparam int unsigned PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [7:0]    div;
  logic [7:0]    hold;
  logic [PW-1:0] start_adrs;
  logic [PW-1:0] end_adrs;
  logic          done;
  logic [PW-1:0] adrs;
  logic          cpu_valid;
  logic          cpu_en;
  logic          cpu_cs;
  logic [7:0]    cpu_wd;
  logic [7:0]    cpu_rd;
  logic          cpu_done;
  logic [7:0]    rd;
  logic          vd;
  logic          full;
  logic          sck;
  logic          cs;
  logic          mosi;
  logic          miso;

  audio_sfm_reader #(.pSfmPageWidth(PW), .pCmdRead(8'h03)) dut (
    .iSCLK(clk), .iSRST(rst), .iSfmEn(en), .iSfmDiv(div), .iSfmCsHoldTime(hold),
    .iSfmStartAdrs(start_adrs), .iSfmEndAdrs(end_adrs), .oSfmDone(done),
    .oSfmAdrsAdd(adrs), .iSfmCpuValid(cpu_valid), .iSfmCpuEn(cpu_en),
    .iSfmCpuCsCtrl(cpu_cs), .iSfmCpuWd(cpu_wd), .oSfmCpuRd(cpu_rd),
    .oSfmCpuDone(cpu_done), .oSfmRd(rd), .oSfmVd(vd), .iSfmFull(full),
    .oSpiSck(sck), .oSpiCs(cs), .oSpiMosi(mosi), .iSpiMiso(miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  exp_q[$];
  logic [31:0] cmd_q[$];
  int vd_cnt, done_cnt, cpu_done_cnt;

  // Flash model: read opcode returns addr[7:0] per byte; CPU mode answers cpu_resp.
  logic        flash_cpu = 1'b0;
  logic [7:0]  cpu_resp  = 8'hEF;
  int          fbits     = 0;
  logic [31:0] mosi_sr   = '0;

  always @(negedge cs) begin
    fbits = 0;
    miso  = flash_cpu ? cpu_resp[7] : 1'b0;
  end
  always @(posedge cs) fbits = 0;

  always @(posedge sck) begin
    if (!cs) begin
      mosi_sr = {mosi_sr[30:0], mosi};
      fbits++;
      if ((flash_cpu && fbits == 8) || (!flash_cpu && fbits == 32)) begin
        if (cmd_q.size() == 0) check("cmd_unexpected", 32'd1, 32'd0);
        else if (flash_cpu) check("cpu_mosi", 32'(mosi_sr[7:0]), cmd_q.pop_front());
        else check("cmd_word", mosi_sr, cmd_q.pop_front());
      end
    end
  end

  always @(negedge sck) begin
    if (!cs) begin
      if (flash_cpu) begin
        miso = cpu_resp[3'(7 - (fbits % 8))];
      end else if (fbits >= 32) begin
        automatic int k = fbits - 32;
        automatic logic [7:0] b = 8'(k / 8);
        miso = b[3'(7 - (k % 8))];
      end
    end
  end

  // Output monitor: every streamed byte is popped against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (vd) begin
        vd_cnt++;
        if (exp_q.size() == 0) check("vd_unexpected", 32'd1, 32'd0);
        else check("rd_byte", 32'(rd), 32'(exp_q.pop_front()));
      end
      if (done) done_cnt++;
      if (cpu_done) cpu_done_cnt++;
    end
  end

  task automatic push_page(input logic [PW-1:0] page, input int nbytes);
    cmd_q.push_back({8'h03, 24'({page, 8'h00})});
    for (int i = 0; i < nbytes; i++) exp_q.push_back(8'(i));
  endtask

  // Waits for oSfmDone (dropping iSfmEn on it), optionally stalling after stall_at bytes.
  task automatic wait_done(input int stall_at, input int gap_exp);
    int  run = 0;
    int  bytes = 0;
    int  viol = 0;
    bit  low_seen = 0;
    bit  got = 0;
    for (int c = 0; c < 20000 && !got; c++) begin
      @(negedge clk);
      if (cs) run++;
      else begin
        if (low_seen && run > 0 && gap_exp > 0) check("cs_gap", 32'(run), 32'(gap_exp));
        run = 0;
        low_seen = 1;
      end
      if (vd) bytes++;
      if (stall_at >= 0 && vd && bytes == stall_at) begin
        full = 1'b1;
        for (int s = 0; s < 50; s++) begin
          @(negedge clk);
          if (sck !== 1'b0 || cs !== 1'b0 || vd !== 1'b0) viol++;
        end
        full = 1'b0;
        check("bp_hold", 32'(viol), 32'd0);
      end
      if (done) begin
        en  = 1'b0;
        got = 1;
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    else begin
      @(negedge clk);
      check("done_width", 32'(done), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div = 8'd0; hold = 8'd2;
    start_adrs = '0; end_adrs = '0; cpu_valid = 1'b0; cpu_en = 1'b0;
    cpu_cs = 1'b1; cpu_wd = 8'h00; full = 1'b0; miso = 1'b0;
    vd_cnt = 0; done_cnt = 0; cpu_done_cnt = 0;
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_pulses", {29'd0, done, vd, cpu_done}, 32'd0);
    check("rst_data", {8'd0, rd, cpu_rd, 8'd0}, 32'd0);
    check("rst_adrs", 32'(adrs), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single page
    start_adrs = 16'h0012; end_adrs = 16'h0012;
    push_page(16'h0012, 256);
    vd_cnt = 0; done_cnt = 0;
    en = 1'b1;
    wait_done(-1, 0);
    repeat (3) @(negedge clk);
    check("single_bytes", 32'(vd_cnt), 32'd256);
    check("single_done", 32'(done_cnt), 32'd1);
    check("single_adrs", 32'(adrs), 32'h0012);
    check("single_cs_idle", 32'(cs), 32'd1);
    check("single_q_empty", 32'(exp_q.size() + cmd_q.size()), 32'd0);

    // Multi-page wrap through 0
    start_adrs = 16'hFFFF; end_adrs = 16'h0001;
    push_page(16'hFFFF, 256); push_page(16'h0000, 256); push_page(16'h0001, 256);
    vd_cnt = 0; done_cnt = 0;
    en = 1'b1;
    wait_done(-1, 2);
    check("wrap_adrs", 32'(adrs), 32'h0001);
    repeat (3) @(negedge clk);
    check("wrap_bytes", 32'(vd_cnt), 32'd768);
    check("wrap_done", 32'(done_cnt), 32'd1);
    check("wrap_q_empty", 32'(exp_q.size() + cmd_q.size()), 32'd0);

    // Backpressure after byte 10, with a slower SCK
    div = 8'd1; start_adrs = 16'h0040; end_adrs = 16'h0040;
    push_page(16'h0040, 256);
    vd_cnt = 0; done_cnt = 0;
    en = 1'b1;
    wait_done(11, 0);
    repeat (3) @(negedge clk);
    check("bp_bytes", 32'(vd_cnt), 32'd256);
    check("bp_done", 32'(done_cnt), 32'd1);
    div = 8'd0;

    // CPU byte
    flash_cpu = 1'b1; cpu_valid = 1'b1; cpu_cs = 1'b0; cpu_wd = 8'h9F;
    cmd_q.push_back(32'h9F);
    repeat (2) @(negedge clk);
    cpu_done_cnt = 0;
    cpu_en = 1'b1;
    begin
      bit got = 0;
      for (int c = 0; c < 2000 && !got; c++) begin
        @(negedge clk);
        if (cpu_done) got = 1;
      end
      check("cpu_done_seen", 32'(got), 32'd1);
    end
    check("cpu_rd", 32'(cpu_rd), 32'hEF);
    repeat (40) @(negedge clk);
    check("cpu_no_retrigger", 32'(cpu_done_cnt), 32'd1);
    check("cpu_cs_follow", 32'(cs), 32'd0);
    cpu_en = 1'b0;
    repeat (3) @(negedge clk);
    cpu_valid = 1'b0; cpu_cs = 1'b1;
    repeat (3) @(negedge clk);
    check("cpu_cs_release", 32'(cs), 32'd1);
    check("cpu_cmd_used", 32'(cmd_q.size()), 32'd0);
    flash_cpu = 1'b0;

    // Disable mid-page: byte 100 in flight completes, then no done
    start_adrs = 16'h0100; end_adrs = 16'h0100;
    push_page(16'h0100, 101);
    vd_cnt = 0; done_cnt = 0;
    en = 1'b1;
    begin
      int bytes = 0;
      for (int c = 0; c < 10000 && bytes < 100; c++) begin
        @(negedge clk);
        if (vd) bytes++;
      end
      check("dis_reach_100", 32'(bytes), 32'd100);
    end
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (200) @(negedge clk);
    check("dis_bytes", 32'(vd_cnt), 32'd101);
    check("dis_no_done", 32'(done_cnt), 32'd0);
    check("dis_cs_high", 32'(cs), 32'd1);

    // Reset mid-DATA, then restart from a new start page
    start_adrs = 16'h0200; end_adrs = 16'h0200;
    push_page(16'h0200, 256);
    vd_cnt = 0;
    en = 1'b1;
    begin
      int bytes = 0;
      for (int c = 0; c < 10000 && bytes < 20; c++) begin
        @(negedge clk);
        if (vd) bytes++;
      end
      check("rstmid_reach_20", 32'(bytes), 32'd20);
    end
    repeat (5) @(negedge clk);
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    check("rstmid_cs", 32'(cs), 32'd1);
    check("rstmid_sck", 32'(sck), 32'd0);
    check("rstmid_pulses", {29'd0, done, vd, cpu_done}, 32'd0);
    exp_q.delete();
    rst = 1'b0;
    start_adrs = 16'h0005; end_adrs = 16'h0005;
    push_page(16'h0005, 256);
    vd_cnt = 0; done_cnt = 0;
    @(negedge clk);
    en = 1'b1;
    wait_done(-1, 0);
    repeat (3) @(negedge clk);
    check("restart_bytes", 32'(vd_cnt), 32'd256);
    check("restart_adrs", 32'(adrs), 32'h0005);
    check("restart_done", 32'(done_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
